// File: rtl/d_format_exec_unit_if.sv
// Handshake, result and host/debug bundle for the D-format executor.
interface d_format_exec_unit_if #(
  parameter int XLEN  = 64,
  parameter int IMM_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       po;
  logic [4:0]       rt;
  logic [4:0]       ra;
  logic [IMM_W-1:0] si;

  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rt;
  logic [XLEN-1:0]  result;
  logic [2:0]       cr0;
  logic             illegal;

  logic             host_we;
  logic [4:0]       host_addr;
  logic [XLEN-1:0]  host_wdata;
  logic [XLEN-1:0]  dbg_rdata;

  modport master (
    output in_valid, po, rt, ra, si, out_ready, host_we, host_addr, host_wdata,
    input  in_ready, out_valid, out_rt, result, cr0, illegal, dbg_rdata
  );

  modport slave (
    input  in_valid, po, rt, ra, si, out_ready, host_we, host_addr, host_wdata,
    output in_ready, out_valid, out_rt, result, cr0, illegal, dbg_rdata
  );
endinterface

// File: rtl/d_format_exec_unit.sv
// Multi-cycle executor for uPower D-format ALU ops (addi/addis/ori/oris/xori/xoris/andi./andis.)
// with its own register file, CR0 update, illegal-op reporting and a host preload/debug port.
module d_format_exec_unit #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int IMM_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  d_format_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

  localparam logic [5:0] PO_ADDI  = 6'd14;
  localparam logic [5:0] PO_ADDIS = 6'd15;
  localparam logic [5:0] PO_ORI   = 6'd24;
  localparam logic [5:0] PO_ORIS  = 6'd25;
  localparam logic [5:0] PO_XORI  = 6'd26;
  localparam logic [5:0] PO_XORIS = 6'd27;
  localparam logic [5:0] PO_ANDI  = 6'd28;
  localparam logic [5:0] PO_ANDIS = 6'd29;

  state_e state_q, state_d;

  logic [5:0]       po_q;
  logic [4:0]       rt_q;
  logic [4:0]       ra_q;
  logic [IMM_W-1:0] si_q;
  logic [XLEN-1:0]  opa_q;
  logic [XLEN-1:0]  result_q;
  logic [4:0]       out_rt_q;
  logic [2:0]       cr0_q;
  logic             illegal_q;
  logic [XLEN-1:0]  regs_q [NREG];

  logic             ra_ok, rt_ok, host_ok, is_arith, is_and, po_known;
  logic [XLEN-1:0]  read_val;
  logic [XLEN-1:0]  imm_s, imm_u;
  logic [XLEN-1:0]  exec_result;
  logic             exec_illegal;
  logic [2:0]       exec_cr0;

  assign ra_ok    = 32'(ra_q) < NREG;
  assign rt_ok    = 32'(rt_q) < NREG;
  assign host_ok  = 32'(bus.host_addr) < NREG;
  assign is_arith = (po_q == PO_ADDI) || (po_q == PO_ADDIS);
  assign is_and   = (po_q == PO_ANDI) || (po_q == PO_ANDIS);

  assign imm_s = {{(XLEN-IMM_W){si_q[IMM_W-1]}}, si_q};
  assign imm_u = {{(XLEN-IMM_W){1'b0}}, si_q};

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand fetch: addi/addis treat RA=0 as the literal zero, logical ops read R0.
  always_comb begin
    read_val = '0;
    if (ra_ok) read_val = regs_q[ra_q];
    if (is_arith && (ra_q == 5'd0)) read_val = '0;
  end

  always_comb begin
    exec_result = '0;
    po_known    = 1'b1;
    unique case (po_q)
      PO_ADDI:  exec_result = opa_q + imm_s;
      PO_ADDIS: exec_result = opa_q + (imm_s << 16);
      PO_ORI:   exec_result = opa_q | imm_u;
      PO_ORIS:  exec_result = opa_q | (imm_u << 16);
      PO_XORI:  exec_result = opa_q ^ imm_u;
      PO_XORIS: exec_result = opa_q ^ (imm_u << 16);
      PO_ANDI:  exec_result = opa_q & imm_u;
      PO_ANDIS: exec_result = opa_q & (imm_u << 16);
      default:  po_known    = 1'b0;
    endcase
    exec_illegal = !po_known || !ra_ok || !rt_ok;
    if (exec_illegal) exec_result = '0;
    exec_cr0 = {exec_result[XLEN-1],
                !exec_result[XLEN-1] && (|exec_result),
                ~|exec_result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_q      <= '0;
      rt_q      <= '0;
      ra_q      <= '0;
      si_q      <= '0;
      opa_q     <= '0;
      result_q  <= '0;
      out_rt_q  <= '0;
      cr0_q     <= '0;
      illegal_q <= 1'b0;
      // NOTE: the register file is architecturally cleared by reset, so it stays in flops
      // with an async reset rather than being mapped to a RAM macro.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if ((state_q == S_IDLE) && bus.in_valid) begin
        po_q <= bus.po;
        rt_q <= bus.rt;
        ra_q <= bus.ra;
        si_q <= bus.si;
      end

      if (state_q == S_READ) opa_q <= read_val;

      if (bus.host_we && host_ok) regs_q[bus.host_addr] <= bus.host_wdata;

      // NOTE: the write-back assignment follows the host write so, with non-blocking
      // semantics, the later one wins when both target the same register on one edge.
      if (state_q == S_EXEC) begin
        result_q  <= exec_result;
        out_rt_q  <= rt_q;
        illegal_q <= exec_illegal;
        if (!exec_illegal) begin
          regs_q[rt_q] <= exec_result;
          if (is_and) cr0_q <= exec_cr0;
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_WB);
  assign bus.out_rt    = out_rt_q;
  assign bus.result    = result_q;
  assign bus.cr0       = cr0_q;
  assign bus.illegal   = illegal_q;
  assign bus.dbg_rdata = host_ok ? regs_q[bus.host_addr] : '0;

endmodule

// File: tb/tb_d_format_exec_unit.sv
// Self-checking bench for d_format_exec_unit: directed vector table, multi-cycle corner
// sequences, then randomized instructions against an arithmetic reference model.
module tb_d_format_exec_unit;
  localparam int XLEN  = 64;
  localparam int NREG  = 24;
  localparam int IMM_W = 16;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  d_format_exec_unit_if #(.XLEN(XLEN), .IMM_W(IMM_W)) bus ();

  d_format_exec_unit #(.XLEN(XLEN), .NREG(NREG), .IMM_W(IMM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [63:0] mregs [32];
  logic [2:0]  mcr0;

  typedef struct {
    logic        pre_en;
    logic [4:0]  pre_addr;
    logic [63:0] pre_data;
    logic [5:0]  po;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [15:0] si;
    logic [63:0] exp_result;
    logic [2:0]  exp_cr0;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] model_exec(input logic [5:0] po, input logic [4:0] rt,
                                             input logic [4:0] ra, input logic [15:0] si);
    logic [63:0] a, s, u, r;
    logic        ill;
    a   = (int'(ra) < NREG) ? mregs[ra] : 64'd0;
    if ((po == 6'd14 || po == 6'd15) && ra == 5'd0) a = 64'd0;
    s   = {{48{si[15]}}, si};
    u   = {48'd0, si};
    ill = 1'b0;
    r   = 64'd0;
    case (po)
      6'd14: r = a + s;
      6'd15: r = a + s * 64'd65536;
      6'd24: r = a | u;
      6'd25: r = a | (u * 64'd65536);
      6'd26: r = a ^ u;
      6'd27: r = a ^ (u * 64'd65536);
      6'd28: r = a & u;
      6'd29: r = a & (u * 64'd65536);
      default: ill = 1'b1;
    endcase
    if (int'(rt) >= NREG || int'(ra) >= NREG) ill = 1'b1;
    if (ill) r = 64'd0;
    return {ill, r};
  endfunction

  function automatic logic [2:0] cr0_of(input logic [63:0] r);
    if ($signed(r) < 0) return 3'b100;
    if (r != 64'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [63:0] model_dbg(input logic [4:0] addr);
    return (int'(addr) < NREG) ? mregs[addr] : 64'd0;
  endfunction

  task automatic host_write(input logic [4:0] addr, input logic [63:0] data);
    bus.host_we    = 1'b1;
    bus.host_addr  = addr;
    bus.host_wdata = data;
    #1;
    check("dbg_before_write", bus.dbg_rdata, model_dbg(addr));
    tick();
    bus.host_we = 1'b0;
    if (int'(addr) < NREG) mregs[addr] = data;
    check("dbg_after_write", bus.dbg_rdata, model_dbg(addr));
  endtask

  task automatic issue(input logic [5:0] po, input logic [4:0] rt, input logic [4:0] ra,
                       input logic [15:0] si);
    for (int i = 0; i < 16 && !bus.in_ready; i++) tick();
    check("issue_in_ready", bus.in_ready, 1);
    bus.po       = po;
    bus.rt       = rt;
    bus.ra       = ra;
    bus.si       = si;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_instr(input logic [5:0] po, input logic [4:0] rt, input logic [4:0] ra,
                          input logic [15:0] si, output logic [63:0] res, output logic ill,
                          output logic [2:0] c, output logic [4:0] ort);
    issue(po, rt, ra, si);
    check("lat_read_valid", bus.out_valid, 0);
    check("lat_read_ready", bus.in_ready, 0);
    tick();
    check("lat_exec_valid", bus.out_valid, 0);
    tick();
    check("lat_wb_valid", bus.out_valid, 1);
    res = bus.result;
    ill = bus.illegal;
    c   = bus.cr0;
    ort = bus.out_rt;
    tick();
    check("ret_idle_ready", bus.in_ready, 1);
    check("ret_idle_valid", bus.out_valid, 0);
  endtask

  task automatic check_dbg(input string name, input logic [4:0] addr);
    bus.host_addr = addr;
    #1;
    check(name, bus.dbg_rdata, model_dbg(addr));
  endtask

  initial begin
    logic [63:0] res, exp_r, old_v;
    logic        ill;
    logic [2:0]  c, exp_c;
    logic [4:0]  ort;
    logic [64:0] m;
    logic [5:0]  po;
    logic [4:0]  rt, ra;
    logic [15:0] si;

    //            pre  addr   data                     po     rt     ra     si        result                   cr0     ill
    vecs[0]  = '{1'b1, 5'd12, 64'd10,                  6'd14, 5'd7,  5'd12, 16'd10,   64'd20,                  3'b000, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  64'd0,                   6'd14, 5'd3,  5'd0,  16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  64'd0,                   6'd28, 5'd7,  5'd12, 16'd5,    64'd0,                   3'b001, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  64'd0,                   6'd24, 5'd7,  5'd12, 16'd5,    64'd15,                  3'b001, 1'b0};
    vecs[4]  = '{1'b1, 5'd4,  64'h7FFF_FFFF_FFFF_FFFF, 6'd15, 5'd5,  5'd4,  16'd1,    64'h8000_0000_0000_FFFF, 3'b001, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  64'd0,                   6'd29, 5'd6,  5'd4,  16'h8000, 64'h0000_0000_8000_0000, 3'b010, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  64'd0,                   6'd27, 5'd8,  5'd5,  16'hFFFF, 64'h8000_0000_FFFF_FFFF, 3'b010, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  64'd0,                   6'd28, 5'd9,  5'd8,  16'h0000, 64'd0,                   3'b001, 1'b0};
    vecs[8]  = '{1'b1, 5'd0,  64'd5,                   6'd25, 5'd10, 5'd0,  16'd1,    64'h0000_0000_0001_0005, 3'b001, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  64'd0,                   6'd14, 5'd11, 5'd0,  16'd3,    64'd3,                   3'b001, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  64'd0,                   6'd26, 5'd0,  5'd12, 16'd3,    64'd9,                   3'b001, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  64'd0,                   6'd31, 5'd7,  5'd12, 16'd0,    64'd0,                   3'b001, 1'b1};
    vecs[12] = '{1'b0, 5'd0,  64'd0,                   6'd14, 5'd7,  5'd24, 16'd1,    64'd0,                   3'b001, 1'b1};
    vecs[13] = '{1'b0, 5'd0,  64'd0,                   6'd24, 5'd30, 5'd12, 16'd1,    64'd0,                   3'b001, 1'b1};
    vecs[14] = '{1'b1, 5'd23, 64'd1,                   6'd14, 5'd23, 5'd23, 16'hFFFF, 64'd0,                   3'b001, 1'b0};
    vecs[15] = '{1'b0, 5'd0,  64'd0,                   6'd14, 5'd1,  5'd12, 16'h8000, 64'hFFFF_FFFF_FFFF_800A, 3'b001, 1'b0};
    vecs[16] = '{1'b0, 5'd0,  64'd0,                   6'd24, 5'd2,  5'd0,  16'h8000, 64'h0000_0000_0000_8009, 3'b001, 1'b0};

    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    mcr0           = 3'b000;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.po         = '0;
    bus.rt         = '0;
    bus.ra         = '0;
    bus.si         = '0;
    bus.out_ready  = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 5'd5;
    bus.host_wdata = '0;

    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_out_rt", bus.out_rt, 0);
    check("rst_cr0", bus.cr0, 0);
    check("rst_illegal", bus.illegal, 0);
    check("rst_dbg", bus.dbg_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].pre_en) host_write(vecs[i].pre_addr, vecs[i].pre_data);
      do_instr(vecs[i].po, vecs[i].rt, vecs[i].ra, vecs[i].si, res, ill, c, ort);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_result);
      check($sformatf("vec%0d_illegal", i), ill, vecs[i].exp_illegal);
      check($sformatf("vec%0d_cr0", i), c, vecs[i].exp_cr0);
      check($sformatf("vec%0d_out_rt", i), ort, vecs[i].rt);
      if (!vecs[i].exp_illegal) mregs[vecs[i].rt] = vecs[i].exp_result;
      mcr0 = vecs[i].exp_cr0;
      check_dbg($sformatf("vec%0d_dbg_rt", i), vecs[i].rt);
    end

    // Backpressure: WB holds for five cycles, a new request during the stall is ignored
    m = model_exec(6'd14, 5'd13, 5'd12, 16'd1);
    bus.out_ready = 1'b0;
    issue(6'd14, 5'd13, 5'd12, 16'd1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_result", bus.result, m[63:0]);
      check("stall_out_rt", bus.out_rt, 13);
      check("stall_in_ready", bus.in_ready, 0);
      if (i == 1) begin
        bus.po       = 6'd14;
        bus.rt       = 5'd20;
        bus.ra       = 5'd0;
        bus.si       = 16'd77;
        bus.in_valid = 1'b1;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stall_release_valid", bus.out_valid, 1);
    tick();
    check("stall_back_idle", bus.in_ready, 1);
    mregs[13] = m[63:0];
    tick();
    tick();
    tick();
    check("stall_ignored_in_ready", bus.in_ready, 1);
    check_dbg("stall_ignored_reg", 5'd20);
    check_dbg("stall_wb_reg", 5'd13);

    // Host write colliding with write-back on the same edge: write-back wins
    m = model_exec(6'd14, 5'd14, 5'd12, 16'd2);
    issue(6'd14, 5'd14, 5'd12, 16'd2);
    tick();
    bus.host_we    = 1'b1;
    bus.host_addr  = 5'd14;
    bus.host_wdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    bus.host_we = 1'b0;
    check("coll_valid", bus.out_valid, 1);
    check("coll_result", bus.result, m[63:0]);
    tick();
    mregs[14] = m[63:0];
    check_dbg("coll_reg", 5'd14);

    // Host write to RA on the READ edge: the operand is the old value
    old_v = mregs[12];
    issue(6'd14, 5'd15, 5'd12, 16'd1);
    bus.host_we    = 1'b1;
    bus.host_addr  = 5'd12;
    bus.host_wdata = 64'd100;
    tick();
    bus.host_we = 1'b0;
    tick();
    check("readedge_valid", bus.out_valid, 1);
    check("readedge_result", bus.result, old_v + 64'd1);
    tick();
    mregs[12] = 64'd100;
    mregs[15] = old_v + 64'd1;
    check_dbg("readedge_ra", 5'd12);
    check_dbg("readedge_rt", 5'd15);

    // Reset asserted during EXEC: discard the instruction
    issue(6'd24, 5'd16, 5'd12, 16'h00FF);
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    mcr0 = 3'b000;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_result", bus.result, 0);
    check("midrst_cr0", bus.cr0, 0);
    check_dbg("midrst_r12", 5'd12);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("midrst_idle", bus.in_ready, 1);
    check("midrst_no_valid", bus.out_valid, 0);
    check_dbg("midrst_target", 5'd16);

    // Randomized instructions against the reference model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        host_write(5'($urandom_range(0, 31)), {$urandom, $urandom});
      case ($urandom_range(0, 9))
        0:       po = 6'($urandom_range(0, 63));
        default: po = 6'($urandom_range(0, 7) + (($urandom_range(0, 3) == 0) ? 14 : 24));
      endcase
      if (po == 6'd16 || po == 6'd17) po = 6'd14;
      rt = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, NREG-1));
      ra = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, NREG-1));
      si = 16'($urandom);
      m     = model_exec(po, rt, ra, si);
      exp_r = m[63:0];
      exp_c = (!m[64] && (po == 6'd28 || po == 6'd29)) ? cr0_of(exp_r) : mcr0;
      do_instr(po, rt, ra, si, res, ill, c, ort);
      check("rand_result", res, exp_r);
      check("rand_illegal", ill, m[64]);
      check("rand_cr0", c, exp_c);
      check("rand_out_rt", ort, rt);
      if (!m[64]) mregs[rt] = exp_r;
      mcr0 = exp_c;
      check_dbg("rand_dbg_rt", rt);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
